systolic_skew_feeder: RTL and testbench
=======================================

Name: systolic_skew_feeder

Overview:
- Upstream edge feeder for the N x N bfloat16 systolic PE array.
- Accepts one k-slice per handshake: column k of A (N elements) and row k of B (N elements).
- Drives the left-edge iRow inputs and top-edge iCol inputs with diagonal skew, so A[i][k] and B[k][j] arrive at PE(i,j) on the same cycle.
- Generates bubbles, zero drain and tile-complete timing; PEs have no stall, so the feeder keeps the stream continuous.

Parameters:
- BW, 16, element width (bfloat16).
- N, 4, array dimension; number of lanes per edge.
- K_MAX, 255, maximum k-slices per tile.
- KW, $clog2(K_MAX+1), width of k_len (derived, not overridden).

Ports:
- clk  in  1  clock, posedge-triggered
- rst_n  in  1  asynchronous active-low reset (negedge-triggered assert)
- start  in  1  begin tile; sampled only in IDLE
- k_len  in  KW  slices in tile; captured with start
- in_valid  in  1  a_vec/b_vec valid
- in_ready  out  1  feeder accepts a slice this cycle
- a_vec  in  N*BW  A[i][k] in bits [i*BW +: BW]
- b_vec  in  N*BW  B[k][j] in bits [j*BW +: BW]
- row_o  out  N*BW  lane i drives iRow of PE(i,0)
- col_o  out  N*BW  lane j drives iCol of PE(0,j)
- busy  out  1  state != IDLE
- tile_done  out  1  one-cycle pulse; all PE oRes final

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-low. The reset-driven reset value of every output is 0 (row_o, col_o, in_ready, busy, tile_done). All delay stages clear to 16'h0000. State goes to IDLE.
- Reset mid-tile aborts the tile. Nothing is retained.
- FSM states: IDLE, STREAM, DRAIN, DONE.
- IDLE:
  - in_ready=0.
  - start=1 captures k_len into the remaining counter.
  - If k_len>=1, go to STREAM. If k_len=0, go to DRAIN.
  - start outside IDLE is ignored.
- STREAM:
  - in_ready=1 combinationally from state.
  - Accept on in_valid & in_ready: push a_vec/b_vec into lane inputs and decrement the counter.
  - When the last slice is accepted (counter==1), go to DRAIN next cycle.
  - When in_valid=0, push 16'h0000 into every lane of both edges in the same cycle. Bubbles on both edges together preserve alignment.
- DRAIN:
  - Push zeros for exactly 2N-1 cycles (7 for N=4), counted by a drain counter, then go to DONE.
- DONE:
  - tile_done=1 for one cycle, then IDLE.
  - start in the DONE cycle is ignored.
- Skew:
  - Lane i (both edges) applies i register stages plus one output register.
  - A slice accepted at edge t appears on lane i output during cycle t+1+i.
  - Lane 0 latency is 1 cycle.
  - Zero pushes traverse the same stages.
- Completion timing: tile_done rises exactly 2N cycles after the clock edge accepting the last slice (8 for N=4). PE(N-1,N-1) oRes has settled by then.
- Accumulator state: the array accumulates across tiles. Clearing PEs between tiles is done by rst_n, outside this block.
- Data handling:
  - No arithmetic; data passes bit-exact.
  - Zero is +0.0 (16'h0000).
- Storage: N*(N-1)/2 skew stages per edge, plus the output registers.

Optional Feature:
- Macro: FEEDER_BUBBLE_CNT_EN.
- Defined: adds output bubble_cnt [15:0].
  - Counts STREAM cycles with in_valid=0.
  - Cleared on reset and on start accepted in IDLE.
  - Saturates at 16'hFFFF.
  - Holds its value after tile_done until the next start.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package systolic_pkg:
  - BW default constant.
  - BF16_ZERO constant (16'h0000).
  - feeder state enum (IDLE, STREAM, DRAIN, DONE).
  - function drain_cycles(N) = 2N-1.
- Sub-module skew_delay_line:
  - Parameters BW and DEPTH; one lane.
  - DEPTH register stages plus output register, async active-low reset to zero.
  - Instantiated 2N times with DEPTH=i.

Test Plan:
1. Reset mid-STREAM with k_len=5 after 2 accepts -> outputs 0 immediately, busy=0, no tile_done; a new start with k_len=1 then runs normally.
2. N=4, k_len=1, a_vec lanes=16'h3F80, b_vec lanes=16'h4000 accepted at edge t -> row_o lane i = 3F80 and col_o lane j = 4000 only in cycle t+1+i (resp. j), else 0; tile_done in cycle t+8; PE(3,3) oRes=16'h4000.
3. k_len=3, in_valid dropped one cycle between slices 1 and 2 -> zero bubble on all 8 lanes in the same cycle; tile_done 8 cycles after the third accept; with FEEDER_BUBBLE_CNT_EN, bubble_cnt=1.
4. k_len=0 with start -> no accept (in_ready stays 0), 7 zero-drain cycles, tile_done pulse, back to IDLE.
5. Full 4x4 tile, k_len=4, A=identity (3F80 diagonal), B rows of 1.0..16.0 in bf16, in_valid held high -> in_ready high for exactly 4 cycles; array oRes equals B at tile_done; start pulsed during STREAM/DRAIN has no effect.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared constants, state encoding and helpers for the systolic array feeder.
package systolic_pkg;

  localparam int BW_DEF = 16;
  localparam logic [15:0] BF16_ZERO = 16'h0000;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    DONE
  } feed_state_e;

  function automatic int drain_cycles(input int n);
    return 2 * n - 1;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// One feeder lane: DEPTH skew registers followed by an output register.
module skew_delay_line
  import systolic_pkg::*;
#(
  parameter int BW    = BW_DEF,
  parameter int DEPTH = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [BW-1:0] i_d,
  output logic [BW-1:0] o_q
);

  // r_pipe[DEPTH] is the output register
  logic [BW-1:0] r_pipe [DEPTH+1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s <= DEPTH; s++) r_pipe[s] <= '0;
    end else begin
      r_pipe[0] <= i_d;
      for (int s = 1; s <= DEPTH; s++) r_pipe[s] <= r_pipe[s-1];
    end
  end

  assign o_q = r_pipe[DEPTH];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Diagonal-skew edge feeder for the N x N bf16 systolic array.
// Optional FEEDER_BUBBLE_CNT_EN adds a saturating bubble_cnt output.
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter  int BW    = BW_DEF,
  parameter  int N     = 4,
  parameter  int K_MAX = 255,
  localparam int KW    = $clog2(K_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [KW-1:0] k_len,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N*BW-1:0] a_vec,
  input  logic [N*BW-1:0] b_vec,
  output logic [N*BW-1:0] row_o,
  output logic [N*BW-1:0] col_o,
  output logic          busy,
  output logic          tile_done
`ifdef FEEDER_BUBBLE_CNT_EN
  ,
  output logic [15:0]   bubble_cnt
`endif
);

  localparam int DC = drain_cycles(N);
  localparam int DW = $clog2(DC + 1);

  feed_state_e r_state;
  feed_state_e w_next;
  logic [KW-1:0] r_left;
  logic [DW-1:0] r_drain;
  logic          w_acc;
  logic          w_last;
  logic [N*BW-1:0] w_a_in;
  logic [N*BW-1:0] w_b_in;

  assign w_acc  = (r_state == STREAM) && in_valid;
  assign w_last = w_acc && (r_left == KW'(1));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (start) w_next = (k_len != '0) ? STREAM : DRAIN;
      end
      STREAM: begin
        if (w_last) w_next = DRAIN;
      end
      DRAIN: begin
        if (r_drain == DW'(DC - 1)) w_next = DONE;
      end
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_left  <= '0;
      r_drain <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && start) r_left <= k_len;
      else if (w_acc)               r_left <= r_left - KW'(1);
      r_drain <= (r_state == DRAIN) ? r_drain + DW'(1) : '0;
    end
  end

  // Bubbles and drain push zeros on both edges together to keep alignment
  assign w_a_in = w_acc ? a_vec : {N{BW'(BF16_ZERO)}};
  assign w_b_in = w_acc ? b_vec : {N{BW'(BF16_ZERO)}};

  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_delay_line #(
      .BW   (BW),
      .DEPTH(i)
    ) u_row (
      .clk  (clk),
      .rst_n(rst_n),
      .i_d  (w_a_in[i*BW +: BW]),
      .o_q  (row_o[i*BW +: BW])
    );
    skew_delay_line #(
      .BW   (BW),
      .DEPTH(i)
    ) u_col (
      .clk  (clk),
      .rst_n(rst_n),
      .i_d  (w_b_in[i*BW +: BW]),
      .o_q  (col_o[i*BW +: BW])
    );
  end

  assign in_ready  = (r_state == STREAM);
  assign busy      = (r_state != IDLE);
  assign tile_done = (r_state == DONE);

`ifdef FEEDER_BUBBLE_CNT_EN
  logic [15:0] r_bub;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bub <= '0;
    end else if (r_state == IDLE && start) begin
      r_bub <= '0;
    end else if (r_state == STREAM && !in_valid && r_bub != 16'hFFFF) begin
      r_bub <= r_bub + 16'd1;
    end
  end

  assign bubble_cnt = r_bub;
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Randomized self-checking bench for systolic_skew_feeder.
module tb_systolic_skew_feeder;

  localparam int BW = 16;
  localparam int N  = 4;
  localparam int KW = 8;
  localparam int DC = 2 * N - 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [KW-1:0]   k_len;
  logic            in_valid;
  logic            in_ready;
  logic [N*BW-1:0] a_vec;
  logic [N*BW-1:0] b_vec;
  logic [N*BW-1:0] row_o;
  logic [N*BW-1:0] col_o;
  logic            busy;
  logic            tile_done;
`ifdef FEEDER_BUBBLE_CNT_EN
  logic [15:0]     bubble_cnt;
`endif

  systolic_skew_feeder #(
    .BW   (BW),
    .N    (N),
    .K_MAX(255)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .k_len    (k_len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_vec    (a_vec),
    .b_vec    (b_vec),
    .row_o    (row_o),
    .col_o    (col_o),
    .busy     (busy),
    .tile_done(tile_done)
`ifdef FEEDER_BUBBLE_CNT_EN
    ,
    .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: slice pushed at edge e shows on lane i after edge e+i;
  // tile_done is seen after edge (last accept or zero-length start) + 2N-1.
  logic [N*BW-1:0] pa_q[$];
  logic [N*BW-1:0] pb_q[$];
  bit m_active;
  int m_left;
  int m_done;
  int edge_n;
  int m_bub;
  int ready_cnt;
  int done_cnt;

  function automatic bit m_ready();
    return m_active && (m_left > 0);
  endfunction

  function automatic logic [15:0] bf16_int(input int v);
    int e;
    int mant;
    e = 0;
    while ((v >> (e + 1)) != 0) e++;
    mant = (v << (7 - e)) & 8'h7F;
    return {1'b0, 8'(127 + e), 7'(mant)};
  endfunction

  task automatic model_reset();
    pa_q.delete();
    pb_q.delete();
    for (int i = 0; i < N; i++) begin
      pa_q.push_front('0);
      pb_q.push_front('0);
    end
    m_active = 0;
    m_left   = 0;
    m_done   = -1;
    edge_n   = 0;
    m_bub    = 0;
  endtask

  task automatic model_edge();
    bit acc;
    acc = m_ready() && in_valid;
    edge_n++;
    pa_q.push_front(acc ? a_vec : '0);
    pb_q.push_front(acc ? b_vec : '0);
    void'(pa_q.pop_back());
    void'(pb_q.pop_back());
    if (m_ready() && !in_valid && m_bub < 65535) m_bub++;
    if (!m_active) begin
      if (start) begin
        m_active = 1;
        m_left   = int'(k_len);
        m_bub    = 0;
        if (k_len == 0) m_done = edge_n + DC;
      end
    end else if (acc) begin
      m_left--;
      if (m_left == 0) m_done = edge_n + DC;
    end else if (m_done >= 0 && edge_n == m_done + 1) begin
      m_active = 0;
      m_done   = -1;
    end
  endtask

  task automatic check_outputs(input string pfx);
    logic [N*BW-1:0] ea;
    logic [N*BW-1:0] eb;
    for (int i = 0; i < N; i++) begin
      ea = pa_q[i];
      eb = pb_q[i];
      check($sformatf("%s_row%0d", pfx, i), 32'(row_o[i*BW +: BW]),
            32'(ea[i*BW +: BW]));
      check($sformatf("%s_col%0d", pfx, i), 32'(col_o[i*BW +: BW]),
            32'(eb[i*BW +: BW]));
    end
    check({pfx, "_busy"}, 32'(busy), 32'(m_active));
    check({pfx, "_done"}, 32'(tile_done), 32'(edge_n == m_done));
`ifdef FEEDER_BUBBLE_CNT_EN
    check({pfx, "_bub"}, 32'(bubble_cnt), 32'(m_bub));
`endif
  endtask

  task automatic step(input bit st, input int kl, input bit v,
                      input logic [N*BW-1:0] a, input logic [N*BW-1:0] b);
    start    = st;
    k_len    = KW'(kl);
    in_valid = v;
    a_vec    = a;
    b_vec    = b;
    #1;
    check("in_ready", 32'(in_ready), 32'(m_ready()));
    if (in_ready) ready_cnt++;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs("cyc");
    if (tile_done) done_cnt++;
    @(negedge clk);
  endtask

  function automatic logic [N*BW-1:0] rnd_vec();
    return {$urandom(), $urandom()};
  endfunction

  // mode 0 random data, 1 constant 1.0/2.0, 2 identity A with B = 1..16
  task automatic run_tile(input int kl, input int vpct,
                          input logic [31:0] vmask, input int mode,
                          input bit spam);
    int c;
    int guard;
    int idx;
    bit v;
    logic [N*BW-1:0] a;
    logic [N*BW-1:0] b;
    c = 0;
    guard = 0;
    ready_cnt = 0;
    done_cnt = 0;
    step(1'b1, kl, 1'b0, rnd_vec(), rnd_vec());
    while (m_active && guard < 300) begin
      idx = kl - m_left;
      v = (vpct < 0) ? vmask[c % 32] : ($urandom_range(99) < vpct);
      if (m_ready()) c++;
      a = rnd_vec();
      b = rnd_vec();
      if (mode == 1) begin
        a = {N{16'h3F80}};
        b = {N{16'h4000}};
      end else if (mode == 2) begin
        for (int i = 0; i < N; i++) begin
          a[i*BW +: BW] = (i == idx) ? 16'h3F80 : 16'h0000;
          b[i*BW +: BW] = bf16_int(N * idx + i + 1);
        end
      end
      step(spam ? 1'($urandom_range(1)) : 1'b0, $urandom_range(7), v, a, b);
      guard++;
    end
    check("tile_end_busy", 32'(busy), 32'd0);
    check("done_pulses", 32'(done_cnt), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    k_len    = '0;
    in_valid = 1'b0;
    a_vec    = '0;
    b_vec    = '0;
    model_reset();
    #3;
    check("rst_ready", 32'(in_ready), 32'd0);
    check_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Abort mid-STREAM, then a clean single-slice tile
    step(1'b1, 5, 1'b0, rnd_vec(), rnd_vec());
    step(1'b0, 0, 1'b1, rnd_vec(), rnd_vec());
    step(1'b0, 0, 1'b1, rnd_vec(), rnd_vec());
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("abort_ready", 32'(in_ready), 32'd0);
    check_outputs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    run_tile(1, 100, '0, 0, 1'b0);

    run_tile(1, 100, '0, 1, 1'b0);
    step(1'b0, 0, 1'b0, '0, '0);

    run_tile(3, -1, 32'b1101, 0, 1'b0);
`ifdef FEEDER_BUBBLE_CNT_EN
    check("t3_bubble", 32'(bubble_cnt), 32'd1);
`endif
    step(1'b0, 0, 1'b0, '0, '0);

    run_tile(0, 100, '0, 0, 1'b0);
    check("t4_ready_cnt", 32'(ready_cnt), 32'd0);

    run_tile(4, 100, '0, 2, 1'b1);
    check("t5_ready_cnt", 32'(ready_cnt), 32'd4);
    step(1'b0, 0, 1'b0, '0, '0);

    for (int t = 0; t < 15; t++) begin
      run_tile($urandom_range(6), $urandom_range(40, 100), '0, 0, 1'b1);
      repeat ($urandom_range(2)) step(1'b0, 0, 1'b0, rnd_vec(), rnd_vec());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
